// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: drives the req/ack handshake to the external data
// memory, freezes upstream stages while an access is in flight, and holds
// the MEM/WB pipeline register that feeds write-back.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  wb_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  wb_out,
  output logic [31:0] rdata_out,
  output logic [31:0] alu_out,
  output logic [4:0]  rd_out,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  // Last counter value before the access is abandoned.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [31:0] cap_q, cap_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [1:0]  wb_q, wb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        access;
  logic        misaligned;

  // Next-state, handshake and MEM/WB load decisions for the current cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    access     = mem_read | mem_write;
    misaligned = access & (alu_in[1:0] != 2'b00);
    stall      = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    abort_d    = abort_q;
    cap_d      = cap_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_d       = wb_q;
    rdata_d    = rdata_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!access) begin
          // Plain ALU op: one-cycle pass-through.
          wb_d    = wb_in;
          alu_d   = alu_in;
          rd_d    = rd_in;
          rdata_d = 32'd0;
        end else if (misaligned) begin
          // Squash write-back and flag the fault; memory is never touched.
          wb_d       = 2'b00;
          alu_d      = alu_in;
          rd_d       = rd_in;
          rdata_d    = 32'd0;
          misalign_d = 1'b1;
        end else begin
          // Launch the access; a write wins when both requests are set.
          stall   = 1'b1;
          wb_d    = 2'b00;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = alu_in;
          wdata_d = wdata_in;
          cnt_d   = 16'd0;
          cap_d   = 32'd0;
          abort_d = 1'b0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        stall = 1'b1;
        wb_d  = 2'b00;
        if (dmem_ack) begin
          cap_d   = we_q ? 32'd0 : dmem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DONE: begin
        // Upstream is still frozen, so the inputs describe the same
        // instruction; returning to IDLE does not restart it because
        // EX/MEM advances on this same edge.
        wb_d      = abort_q ? 2'b00 : wb_in;
        alu_d     = alu_in;
        rd_d      = rd_in;
        rdata_d   = cap_q;
        bus_err_d = abort_q;
        abort_d   = 1'b0;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset that overrides any in-flight access.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      abort_q    <= 1'b0;
      cap_q      <= 32'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wb_q       <= 2'b00;
      rdata_q    <= 32'd0;
      alu_q      <= 32'd0;
      rd_q       <= 5'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      abort_q    <= abort_d;
      cap_q      <= cap_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_q       <= wb_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_out       = wb_q;
  assign rdata_out    = rdata_q;
  assign alu_out      = alu_q;
  assign rd_out       = rd_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a short timeout so the abort path
// is reachable in a few cycles.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  wb_in;
  logic [31:0] alu_in, wdata_in;
  logic [4:0]  rd_in;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  wb_out;
  logic [31:0] rdata_out, alu_out;
  logic [4:0]  rd_out;
  logic        misalign_err, bus_err;

  int n_vec = 0;
  int n_err = 0;
  int stall_total = 0;
  int s0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_in(wb_in), .alu_in(alu_in), .wdata_in(wdata_in), .rd_in(rd_in),
    .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_out(wb_out), .rdata_out(rdata_out), .alu_out(alu_out), .rd_out(rd_out),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Count cycles with stall high, sampled mid-cycle.
  always @(negedge clk) if (stall) stall_total++;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic [1:0] wb,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rdst);
    mem_read  = rd;
    mem_write = wr;
    wb_in     = wb;
    alu_in    = alu;
    wdata_in  = wd;
    rd_in     = rdst;
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    tick();
    check("rst_wb", 32'(wb_out), 32'd0);
    check("rst_alu", alu_out, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_mis", 32'(misalign_err), 32'd0);
    check("rst_berr", 32'(bus_err), 32'd0);
    rst = 1'b0;

    // ALU op pass-through.
    set_in(1'b0, 1'b0, 2'b10, 32'h1234, 32'd0, 5'd5);
    #1 check("alu_stall", 32'(stall), 32'd0);
    tick();
    check("alu_wb", 32'(wb_out), 32'd2);
    check("alu_alu", alu_out, 32'h1234);
    check("alu_rd", 32'(rd_out), 32'd5);
    check("alu_rdata", rdata_out, 32'd0);
    check("alu_req", 32'(dmem_req), 32'd0);

    // Load at 0x40, ack one cycle after req.
    set_in(1'b1, 1'b0, 2'b11, 32'h40, 32'd0, 5'd7);
    s0 = stall_total;
    #1 check("ld_stall_idle", 32'(stall), 32'd1);
    tick();
    check("ld_req", 32'(dmem_req), 32'd1);
    check("ld_we", 32'(dmem_we), 32'd0);
    check("ld_addr", dmem_addr, 32'h40);
    check("ld_bubble", 32'(wb_out), 32'd0);
    check("ld_alu_hold", alu_out, 32'h1234);
    check("ld_stall_busy", 32'(stall), 32'd1);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    tick();
    dmem_ack = 1'b0;
    check("ld_req_drop", 32'(dmem_req), 32'd0);
    check("ld_stall_done", 32'(stall), 32'd0);
    check("ld_bubble2", 32'(wb_out), 32'd0);
    tick();
    check("ld_wb", 32'(wb_out), 32'd3);
    check("ld_rdata", rdata_out, 32'hDEADBEEF);
    check("ld_alu", alu_out, 32'h40);
    check("ld_rd", 32'(rd_out), 32'd7);
    check("ld_stalls", 32'(stall_total - s0), 32'd2);

    // Store at 0x80, ack in the fourth BUSY cycle.
    set_in(1'b0, 1'b1, 2'b01, 32'h80, 32'hA5A5A5A5, 5'd9);
    s0 = stall_total;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      check("st_req", 32'(dmem_req), 32'd1);
      check("st_we", 32'(dmem_we), 32'd1);
      check("st_addr", dmem_addr, 32'h80);
      check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    end
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11111111;
    tick();
    dmem_ack = 1'b0;
    check("st_req_drop", 32'(dmem_req), 32'd0);
    check("st_we_drop", 32'(dmem_we), 32'd0);
    tick();
    check("st_wb", 32'(wb_out), 32'd1);
    check("st_rdata", rdata_out, 32'd0);
    check("st_alu", alu_out, 32'h80);
    check("st_rd", 32'(rd_out), 32'd9);
    check("st_stalls", 32'(stall_total - s0), 32'd5);

    // Misaligned load at 0x41.
    set_in(1'b1, 1'b0, 2'b11, 32'h41, 32'd0, 5'd3);
    #1 check("mis_stall", 32'(stall), 32'd0);
    tick();
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_wb", 32'(wb_out), 32'd0);
    check("mis_alu", alu_out, 32'h41);
    check("mis_rd", 32'(rd_out), 32'd3);
    set_in(1'b0, 1'b0, 2'b10, 32'h55, 32'd0, 5'd4);
    tick();
    check("mis_pulse", 32'(misalign_err), 32'd0);
    check("mis_next_wb", 32'(wb_out), 32'd2);

    // Load with no ack: abort after four BUSY cycles.
    set_in(1'b1, 1'b0, 2'b11, 32'h100, 32'd0, 5'd6);
    s0 = stall_total;
    tick();
    tick();
    tick();
    tick();
    check("to_req_held", 32'(dmem_req), 32'd1);
    tick();
    check("to_req_drop", 32'(dmem_req), 32'd0);
    check("to_berr_early", 32'(bus_err), 32'd0);
    check("to_stall_done", 32'(stall), 32'd0);
    tick();
    check("to_berr", 32'(bus_err), 32'd1);
    check("to_wb", 32'(wb_out), 32'd0);
    check("to_alu", alu_out, 32'h100);
    check("to_rd", 32'(rd_out), 32'd6);
    check("to_rdata", rdata_out, 32'd0);
    check("to_stalls", 32'(stall_total - s0), 32'd5);
    set_in(1'b0, 1'b0, 2'b10, 32'h77, 32'd0, 5'd2);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ack = 1'b0;
    check("late_berr", 32'(bus_err), 32'd0);
    check("late_wb", 32'(wb_out), 32'd2);
    check("late_alu", alu_out, 32'h77);
    check("late_rdata", rdata_out, 32'd0);
    check("late_req", 32'(dmem_req), 32'd0);

    // Reset in the second BUSY cycle.
    set_in(1'b1, 1'b0, 2'b11, 32'h200, 32'd0, 5'd8);
    tick();
    tick();
    rst = 1'b1;
    set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();
    check("mr_req", 32'(dmem_req), 32'd0);
    check("mr_addr", dmem_addr, 32'd0);
    check("mr_wb", 32'(wb_out), 32'd0);
    check("mr_alu", alu_out, 32'd0);
    check("mr_rd", 32'(rd_out), 32'd0);
    check("mr_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    set_in(1'b1, 1'b0, 2'b11, 32'h300, 32'd0, 5'd10);
    #1 check("mr_ld_stall", 32'(stall), 32'd1);
    tick();
    check("mr_ld_req", 32'(dmem_req), 32'd1);
    check("mr_ld_addr", dmem_addr, 32'h300);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h12345678;
    tick();
    dmem_ack = 1'b0;
    tick();
    check("mr_ld_wb", 32'(wb_out), 32'd3);
    check("mr_ld_rdata", rdata_out, 32'h12345678);
    check("mr_ld_rd", 32'(rd_out), 32'd10);
    set_in(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
